// File: rtl/elevator_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : elevator_scheduler
// Purpose  : Request latch plus SCAN motion/door controller for a small
//            elevator. Requests are accepted only under a valid login session.
//            All outputs are registered.
// Revision : 1.0 - initial release
// ============================================================================
module elevator_scheduler #(
    parameter int NFLOORS     = 3,
    parameter int DOOR_CYCLES = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NFLOORS-1:0] reqin_i,
    input  logic [NFLOORS-1:0] reqout_i,
    input  logic               auth_car_i,
    input  logic [NFLOORS-1:0] auth_hall_i,
    input  logic [NFLOORS-1:0] pres_i,
    output logic [NFLOORS-1:0] door_o,
    output logic [1:0]         dir_o,
    output logic [NFLOORS-1:0] pending_o,
    output logic               fault_o
);

    localparam int FW = (NFLOORS > 1) ? $clog2(NFLOORS) : 1;
    localparam int TW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(DOOR_CYCLES - 1);

    localparam logic [1:0] DIR_STOP = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MOVE  = 3'd1,
        S_OPEN  = 3'd2,
        S_CLOSE = 3'd3,
        S_FAULT = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [NFLOORS-1:0]  pending_q, pending_d;
    logic [NFLOORS-1:0]  door_q, door_d;
    logic [1:0]          dir_q, dir_d;
    logic [1:0]          last_dir_q, last_dir_d;
    logic                fault_q, fault_d;
    logic [FW-1:0]       last_floor_q, last_floor_d;
    logic [TW-1:0]       timer_q, timer_d;

    logic [NFLOORS-1:0]  acc;
    logic                pres_multi;
    logic                pres_onehot;
    logic [FW-1:0]       pres_idx;
    logic [FW-1:0]       cur_floor;
    logic [NFLOORS-1:0]  above_mask;
    logic [NFLOORS-1:0]  below_mask;
    logic                has_above;
    logic                has_below;
    logic                ahead;
    logic [1:0]          pick_dir;

    // Requests that survive the login gate this cycle
    assign acc = (reqin_i & {NFLOORS{auth_car_i}}) | (reqout_i & auth_hall_i);

    // Sensor decode: more than one bit set is a fault, exactly one is a floor
    assign pres_multi  = |(pres_i & (pres_i - NFLOORS'(1)));
    assign pres_onehot = (pres_i != '0) && !pres_multi;

    // Floor index of the sensor and masks of floors above/below the car
    always_comb begin
        pres_idx = '0;
        for (int i = 0; i < NFLOORS; i++) begin
            if (pres_i[i]) begin
                pres_idx = FW'(i);
            end
        end
        cur_floor = pres_onehot ? pres_idx : last_floor_q;
        for (int i = 0; i < NFLOORS; i++) begin
            above_mask[i] = (FW'(i) > cur_floor);
            below_mask[i] = (FW'(i) < cur_floor);
        end
    end

    // SCAN direction choice: keep going the last way while work lies ahead
    always_comb begin
        has_above = |(pending_q & above_mask);
        has_below = |(pending_q & below_mask);
        ahead     = (dir_q == DIR_UP) ? has_above : has_below;
        if (has_above && (!has_below || last_dir_q != DIR_DOWN)) begin
            pick_dir = DIR_UP;
        end else if (has_below) begin
            pick_dir = DIR_DOWN;
        end else begin
            pick_dir = DIR_STOP;
        end
    end

    // Next-state, request bookkeeping and registered output values
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q | acc;
        door_d       = door_q;
        dir_d        = dir_q;
        last_dir_d   = last_dir_q;
        fault_d      = fault_q;
        timer_d      = timer_q;
        last_floor_d = pres_onehot ? pres_idx : last_floor_q;

        if (pres_multi) begin
            // Conflicting sensor reading: halt everything, keep the queue
            state_d = S_FAULT;
            door_d  = '0;
            dir_d   = DIR_STOP;
            fault_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    door_d = '0;
                    dir_d  = DIR_STOP;
                    if (pres_onehot && |((pending_q | acc) & pres_i)) begin
                        state_d   = S_OPEN;
                        door_d    = pres_i;
                        timer_d   = TIMER_LOAD;
                        pending_d = (pending_q | acc) & ~pres_i;
                    end else if (pick_dir != DIR_STOP) begin
                        state_d    = S_MOVE;
                        dir_d      = pick_dir;
                        last_dir_d = pick_dir;
                    end
                end
                S_MOVE: begin
                    if (pres_onehot) begin
                        if (|(pending_q & pres_i)) begin
                            state_d   = S_OPEN;
                            door_d    = pres_i;
                            dir_d     = DIR_STOP;
                            timer_d   = TIMER_LOAD;
                            pending_d = (pending_q | acc) & ~pres_i;
                        end else if (!ahead) begin
                            // Nothing further this way (e.g. end of shaft)
                            state_d = S_CLOSE;
                            dir_d   = DIR_STOP;
                        end
                    end
                end
                S_OPEN: begin
                    dir_d     = DIR_STOP;
                    // A call for the open floor is served by the open door
                    pending_d = (pending_q | acc) & ~door_q;
                    if (|(acc & door_q)) begin
                        timer_d = TIMER_LOAD;
                    end else if (timer_q == '0) begin
                        state_d = S_CLOSE;
                        door_d  = '0;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                S_CLOSE: begin
                    door_d = '0;
                    if (pick_dir != DIR_STOP) begin
                        state_d    = S_MOVE;
                        dir_d      = pick_dir;
                        last_dir_d = pick_dir;
                    end else begin
                        state_d = S_IDLE;
                        dir_d   = DIR_STOP;
                    end
                end
                S_FAULT: begin
                    door_d = '0;
                    dir_d  = DIR_STOP;
                    if (pres_onehot) begin
                        state_d = S_IDLE;
                        fault_d = 1'b0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    door_d  = '0;
                    dir_d   = DIR_STOP;
                end
            endcase
        end
    end

    // State and output registers; reset stops the car and shuts the doors
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            pending_q    <= '0;
            door_q       <= '0;
            dir_q        <= DIR_STOP;
            last_dir_q   <= DIR_STOP;
            fault_q      <= 1'b0;
            last_floor_q <= '0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            door_q       <= door_d;
            dir_q        <= dir_d;
            last_dir_q   <= last_dir_d;
            fault_q      <= fault_d;
            last_floor_q <= last_floor_d;
            timer_q      <= timer_d;
        end
    end

    assign door_o    = door_q;
    assign dir_o     = dir_q;
    assign pending_o = pending_q;
    assign fault_o   = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_elevator_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_elevator_scheduler
// Purpose  : Directed cycle-by-cycle vectors plus hand-written sequences for
//            door-timer reload, sensor fault and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_elevator_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] reqin = '0;
    logic [2:0] reqout = '0;
    logic       auth_car = 1'b0;
    logic [2:0] auth_hall = '0;
    logic [2:0] pres = 3'b001;
    logic [2:0] door;
    logic [1:0] dir;
    logic [2:0] pending;
    logic       fault;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] reqin;
        logic [2:0] reqout;
        logic       auth_car;
        logic [2:0] auth_hall;
        logic [2:0] pres;
        logic [2:0] door;
        logic [1:0] dir;
        logic [2:0] pend;
        logic       fault;
    } vec_t;

    vec_t vecs[$];

    elevator_scheduler #(.NFLOORS(3), .DOOR_CYCLES(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .reqin_i     (reqin),
        .reqout_i    (reqout),
        .auth_car_i  (auth_car),
        .auth_hall_i (auth_hall),
        .pres_i      (pres),
        .door_o      (door),
        .dir_o       (dir),
        .pending_o   (pending),
        .fault_o     (fault)
    );

    always #5 clk = ~clk;

    task automatic add(input logic [2:0] rc, input logic [2:0] ro, input logic ac,
                       input logic [2:0] ah, input logic [2:0] pr, input logic [2:0] d,
                       input logic [1:0] dr, input logic [2:0] pd, input logic f);
        vec_t v;
        v.reqin = rc; v.reqout = ro; v.auth_car = ac; v.auth_hall = ah; v.pres = pr;
        v.door = d; v.dir = dr; v.pend = pd; v.fault = f;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [2:0] d, input logic [1:0] dr,
                         input logic [2:0] pd, input logic f);
        checks++;
        if (door !== d || dir !== dr || pending !== pd || fault !== f) begin
            errors++;
            $display("FAIL %s: got door=%b dir=%b pending=%b fault=%b, want door=%b dir=%b pending=%b fault=%b",
                     name, door, dir, pending, fault, d, dr, pd, f);
        end
    endtask

    // Apply inputs on the falling edge, then let one rising edge pass
    task automatic step(input logic [2:0] rc, input logic [2:0] ro, input logic ac,
                        input logic [2:0] ah, input logic [2:0] pr);
        @(negedge clk);
        reqin = rc; reqout = ro; auth_car = ac; auth_hall = ah; pres = pr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Unauthenticated hall call dropped, then authenticated trip 0 -> 2
        add(3'b000, 3'b100, 0, 3'b000, 3'b001, 3'b000, 2'b00, 3'b000, 0);
        add(3'b000, 3'b100, 0, 3'b000, 3'b001, 3'b000, 2'b00, 3'b000, 0);
        add(3'b000, 3'b100, 0, 3'b100, 3'b001, 3'b000, 2'b00, 3'b100, 0);
        add(3'b000, 3'b000, 0, 3'b000, 3'b001, 3'b000, 2'b01, 3'b100, 0);
        add(3'b000, 3'b000, 0, 3'b000, 3'b000, 3'b000, 2'b01, 3'b100, 0);
        add(3'b000, 3'b000, 0, 3'b000, 3'b010, 3'b000, 2'b01, 3'b100, 0);
        add(3'b000, 3'b000, 0, 3'b000, 3'b100, 3'b100, 2'b00, 3'b000, 0);
        add(3'b000, 3'b000, 0, 3'b000, 3'b100, 3'b100, 2'b00, 3'b000, 0);
        add(3'b000, 3'b000, 0, 3'b000, 3'b100, 3'b100, 2'b00, 3'b000, 0);
        add(3'b000, 3'b000, 0, 3'b000, 3'b100, 3'b100, 2'b00, 3'b000, 0);
        add(3'b000, 3'b000, 0, 3'b000, 3'b100, 3'b000, 2'b00, 3'b000, 0);
        add(3'b000, 3'b000, 0, 3'b000, 3'b100, 3'b000, 2'b00, 3'b000, 0);
        // Car call from floor 2 to floor 0, passing floor 1 without stopping
        add(3'b001, 3'b000, 1, 3'b000, 3'b100, 3'b000, 2'b00, 3'b001, 0);
        add(3'b000, 3'b000, 0, 3'b000, 3'b100, 3'b000, 2'b10, 3'b001, 0);
        add(3'b000, 3'b000, 0, 3'b000, 3'b010, 3'b000, 2'b10, 3'b001, 0);
        add(3'b000, 3'b000, 0, 3'b000, 3'b001, 3'b001, 2'b00, 3'b000, 0);
        add(3'b000, 3'b000, 0, 3'b000, 3'b001, 3'b001, 2'b00, 3'b000, 0);
        add(3'b000, 3'b000, 0, 3'b000, 3'b001, 3'b001, 2'b00, 3'b000, 0);
        add(3'b000, 3'b000, 0, 3'b000, 3'b001, 3'b001, 2'b00, 3'b000, 0);
        add(3'b000, 3'b000, 0, 3'b000, 3'b001, 3'b000, 2'b00, 3'b000, 0);
        add(3'b000, 3'b000, 0, 3'b000, 3'b001, 3'b000, 2'b00, 3'b000, 0);
        // SCAN: up to 1 and 2 before returning for the floor-0 hall call
        add(3'b110, 3'b000, 1, 3'b000, 3'b001, 3'b000, 2'b00, 3'b110, 0);
        add(3'b000, 3'b000, 0, 3'b000, 3'b001, 3'b000, 2'b01, 3'b110, 0);
        add(3'b000, 3'b000, 0, 3'b000, 3'b000, 3'b000, 2'b01, 3'b110, 0);
        add(3'b000, 3'b001, 0, 3'b001, 3'b000, 3'b000, 2'b01, 3'b111, 0);
        add(3'b000, 3'b000, 0, 3'b000, 3'b010, 3'b010, 2'b00, 3'b101, 0);
        add(3'b000, 3'b000, 0, 3'b000, 3'b010, 3'b010, 2'b00, 3'b101, 0);
        add(3'b000, 3'b000, 0, 3'b000, 3'b010, 3'b010, 2'b00, 3'b101, 0);
        add(3'b000, 3'b000, 0, 3'b000, 3'b010, 3'b010, 2'b00, 3'b101, 0);
        add(3'b000, 3'b000, 0, 3'b000, 3'b010, 3'b000, 2'b00, 3'b101, 0);
        add(3'b000, 3'b000, 0, 3'b000, 3'b010, 3'b000, 2'b01, 3'b101, 0);
        add(3'b000, 3'b000, 0, 3'b000, 3'b000, 3'b000, 2'b01, 3'b101, 0);
        add(3'b000, 3'b000, 0, 3'b000, 3'b100, 3'b100, 2'b00, 3'b001, 0);
        add(3'b000, 3'b000, 0, 3'b000, 3'b100, 3'b100, 2'b00, 3'b001, 0);
        add(3'b000, 3'b000, 0, 3'b000, 3'b100, 3'b100, 2'b00, 3'b001, 0);
        add(3'b000, 3'b000, 0, 3'b000, 3'b100, 3'b100, 2'b00, 3'b001, 0);
        add(3'b000, 3'b000, 0, 3'b000, 3'b100, 3'b000, 2'b00, 3'b001, 0);
        add(3'b000, 3'b000, 0, 3'b000, 3'b100, 3'b000, 2'b10, 3'b001, 0);
        add(3'b000, 3'b000, 0, 3'b000, 3'b010, 3'b000, 2'b10, 3'b001, 0);
        add(3'b000, 3'b000, 0, 3'b000, 3'b001, 3'b001, 2'b00, 3'b000, 0);
        add(3'b000, 3'b000, 0, 3'b000, 3'b001, 3'b001, 2'b00, 3'b000, 0);
        add(3'b000, 3'b000, 0, 3'b000, 3'b001, 3'b001, 2'b00, 3'b000, 0);
        add(3'b000, 3'b000, 0, 3'b000, 3'b001, 3'b001, 2'b00, 3'b000, 0);
        add(3'b000, 3'b000, 0, 3'b000, 3'b001, 3'b000, 2'b00, 3'b000, 0);
        add(3'b000, 3'b000, 0, 3'b000, 3'b001, 3'b000, 2'b00, 3'b000, 0);

        // Power-on reset
        #1 rst_n = 1'b0;
        #1 check("reset_state", 3'b000, 2'b00, 3'b000, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].reqin, vecs[i].reqout, vecs[i].auth_car, vecs[i].auth_hall, vecs[i].pres);
            check($sformatf("vec%0d", i), vecs[i].door, vecs[i].dir, vecs[i].pend, vecs[i].fault);
        end

        // Door-timer reload at floor 1 from a same-floor hall call
        step(3'b010, 3'b000, 1, 3'b000, 3'b001);
        check("reload_req", 3'b000, 2'b00, 3'b010, 1'b0);
        step(3'b000, 3'b000, 0, 3'b000, 3'b001);
        check("reload_up", 3'b000, 2'b01, 3'b010, 1'b0);
        step(3'b000, 3'b000, 0, 3'b000, 3'b010);
        check("reload_open", 3'b010, 2'b00, 3'b000, 1'b0);
        step(3'b000, 3'b000, 0, 3'b000, 3'b010);
        step(3'b000, 3'b000, 0, 3'b000, 3'b010);
        check("reload_t1", 3'b010, 2'b00, 3'b000, 1'b0);
        step(3'b000, 3'b010, 0, 3'b010, 3'b010);
        check("reload_hit", 3'b010, 2'b00, 3'b000, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(3'b000, 3'b000, 0, 3'b000, 3'b010);
            check($sformatf("reload_hold%0d", k), 3'b010, 2'b00, 3'b000, 1'b0);
        end
        step(3'b000, 3'b000, 0, 3'b000, 3'b010);
        check("reload_close", 3'b000, 2'b00, 3'b000, 1'b0);
        step(3'b000, 3'b000, 0, 3'b000, 3'b010);
        check("reload_idle", 3'b000, 2'b00, 3'b000, 1'b0);

        // Sensor fault during motion, queue still accepts, recovery
        step(3'b100, 3'b000, 1, 3'b000, 3'b010);
        check("fault_req", 3'b000, 2'b00, 3'b100, 1'b0);
        step(3'b000, 3'b000, 0, 3'b000, 3'b010);
        check("fault_move", 3'b000, 2'b01, 3'b100, 1'b0);
        step(3'b000, 3'b000, 0, 3'b000, 3'b011);
        check("fault_set", 3'b000, 2'b00, 3'b100, 1'b1);
        step(3'b001, 3'b000, 1, 3'b000, 3'b000);
        check("fault_accept", 3'b000, 2'b00, 3'b101, 1'b1);
        step(3'b000, 3'b000, 0, 3'b000, 3'b010);
        check("fault_clear", 3'b000, 2'b00, 3'b101, 1'b0);
        step(3'b000, 3'b000, 0, 3'b000, 3'b010);
        check("fault_resume", 3'b000, 2'b01, 3'b101, 1'b0);

        // Asynchronous reset mid-motion takes effect before the next edge
        #2 rst_n = 1'b0;
        #1 check("async_reset", 3'b000, 2'b00, 3'b000, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        step(3'b000, 3'b000, 0, 3'b000, 3'b010);
        check("post_reset", 3'b000, 2'b00, 3'b000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/elevator_scheduler.md
# elevator_scheduler

Request scheduler and motion/door controller for the 3-floor elevator with login. Latches car-panel and hall-call requests, accepting each only when the login block reports a valid session for that panel. Drives the car direction and per-floor door outputs with a SCAN (keep-direction) policy. Sits between the per-floor and in-car login controllers and the floor sensors and motor/door actuators.

## Interface
- NFLOORS, 3: number of floors; all floor vectors are NFLOORS bits, bit 0 = ground floor.
- DOOR_CYCLES, 4: clock cycles a door stays open per stop (≥2).
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- reqin  in  NFLOORS  car-panel floor requests, multi-hot, level-sampled each cycle.
- reqout  in  NFLOORS  hall-call requests, one bit per floor.
- auth_car  in  1  in-car login session valid; gates reqin.
- auth_hall  in  NFLOORS  per-floor login session valid; auth_hall[i] gates reqout[i].
- pres  in  NFLOORS  floor sensor; one-hot = car at that floor, 0 = between floors.
- door  out  NFLOORS  door open, one-hot or 0.
- dir  out  2  motor command: 00 stop, 01 up, 10 down; 11 never driven.
- pending  out  NFLOORS  latched outstanding requests.
- fault  out  1  sensor fault flag.

## Operation
- Accept: acc = (reqin & {NFLOORS{auth_car}}) | (reqout & auth_hall). pending |= acc at each edge. Unauthenticated requests are dropped, not queued.
- last_floor register (index): loaded from pres whenever pres is one-hot; reset value 0.
- States: IDLE, MOVE, OPEN, CLOSE, FAULT.
- IDLE: dir=00, door=0. If pending has the bit for the current pres floor (or acc does) → OPEN. Else if any pending above last_floor → MOVE up; else if any below → MOVE down. Up wins when both exist and last travel direction was up or none; down wins otherwise.
- MOVE: dir held at 01/10. When pres one-hot and pending at that floor is set → OPEN. dir never changes mid-MOVE.
- OPEN: door=pres latched at entry, dir=00; timer loaded DOOR_CYCLES-1, decrements each cycle. pending bit of that floor cleared on entry. A new accepted request for the same floor while OPEN reloads the timer and is not latched. Timer 0 → CLOSE.
- CLOSE: door=0 for exactly one cycle, dir=00. Next state: MOVE in last direction if pending ahead; else MOVE reversed if pending behind; else IDLE.
- Travel boundary: a request beyond top/bottom cannot exist; at floor NFLOORS-1 moving up, or floor 0 moving down, with no matching pending → CLOSE-equivalent decision (stop, dir=00, pick next).
- FAULT: pres with >1 bit set, in any state → FAULT next edge: dir=00, door=0, fault=1; pending retained and still accepts. Exit to IDLE on the first cycle pres is one-hot again; fault clears then.
- Simultaneous set and clear of the same pending bit (OPEN entry): clear wins.

## Timing
- Reset (rst=0, async): state IDLE, door=000, dir=00, pending=000, fault=0, last_floor=0, timer=0. Applies immediately mid-motion or mid-door; the car is stopped and doors close on assertion.
- Request latency: pending visible 1 cycle after the accepting edge.
- IDLE → motion: dir asserted at the edge after pending becomes visible (2 cycles from request).
- Arrival: door asserted and dir=00 at the edge sampling pres matching pending (1 cycle).
- Door open exactly DOOR_CYCLES cycles, then 1 CLOSE cycle, then next dir at the following edge.
- All outputs registered; no combinational input-to-output path.

## Test plan
- Reset mid-MOVE (dir=01), assert rst=0 → door=000, dir=00, pending=000 immediately, before next clk edge.
- Car at floor 0 (pres=001), reqout=100 with auth_hall=000 → pending stays 000, dir stays 00; repeat with auth_hall=100 → pending=100 next cycle, dir=01 the cycle after; pres=100 → door=100 for 4 cycles, pending=000, then door=000, dir=00.
- Car at floor 2 (pres=100), auth_car=1, reqin=001 for one cycle → dir=10; drive pres 010 then 001 → no stop at floor 1, door=001 on arrival.
- SCAN: moving up from floor 0 with pending=110, then hall call at floor 0 arrives → stops at floor 1, then floor 2, only then dir=10 to floor 0.
- Car at floor 1 in OPEN, reqout=010 with auth_hall=010 at timer=1 → timer reloads, door=010 for 4 more cycles, pending[1] stays 0.
- pres=011 during MOVE → next edge dir=00, door=000, fault=1, pending unchanged; pres=010 → fault=0, state IDLE, service resumes.
